// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the instruction loader
package loader_pkg;

  localparam int W = 9;
  localparam logic [7:0] HI_RSVD_MASK = 8'hFE;

  typedef enum logic [2:0] {IDLE, LO, HI, WRITE, DONE} state_t;

endpackage

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - packs byte pairs into 9-bit words and writes them
// to the instruction store at consecutive addresses from a base.
module instr_loader
  import loader_pkg::*;
#(
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] base_addr,
  input  logic [D:0]   word_count,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [W-1:0] wr_data,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [W-1:0] checksum
);

  state_t       state, state_next;
  logic [D-1:0] base_q;
  logic [D:0]   count_q;
  logic [D:0]   index_q;
  logic [7:0]   lo_q;
  logic         hi_bad;
  logic         last_word;

  assign hi_bad    = (byte_in & HI_RSVD_MASK) != 8'h00;
  assign last_word = (index_q + {{D{1'b0}}, 1'b1}) == count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (word_count == '0) ? DONE : LO;
      end
      LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = HI;
      end
      HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = hi_bad ? DONE : WRITE;
      end
      WRITE: begin
        wr_en      = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? DONE : LO;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // wr_addr/wr_data are loaded on the HI accept so they are registered
  // for the whole WRITE cycle and simply hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q   <= '0;
      count_q  <= '0;
      index_q  <= '0;
      lo_q     <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      error    <= 1'b0;
      checksum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            count_q  <= word_count;
            index_q  <= '0;
            error    <= 1'b0;
            checksum <= '0;
          end
        end
        LO: begin
          if (byte_valid) lo_q <= byte_in;
        end
        HI: begin
          if (byte_valid) begin
            if (hi_bad) begin
              error <= 1'b1;
            end else begin
              wr_addr <= base_q + index_q[D-1:0];
              wr_data <= {byte_in[0], lo_q};
            end
          end
        end
        WRITE: begin
          checksum <= checksum + wr_data;
          index_q  <= index_q + {{D{1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule
